// File: rtl/btn_cond_array.sv
// btn_cond_array: multi-channel push-button conditioner (sync, debounce FSM, press/release strobes).
// Define BTN_REPEAT_EN to add long-press auto-repeat on press_o.
module btn_cond_array #(
    parameter int NUM_BTN       = 2,
    parameter int NUM_SYNC      = 2,
    parameter int BTN_ACTIVE    = 1,
    parameter int DEBOUNCE      = 100000,
    parameter int EXCLUSIVE     = 0,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic               any_press_o
);
    localparam int MAX1 = (DEBOUNCE > HOLD_CYCLES) ? DEBOUNCE : HOLD_CYCLES;
    localparam int MAXC = (MAX1 > REPEAT_CYCLES) ? MAX1 : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DB_C = CW'(DEBOUNCE);
`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] HD_C = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RP_C = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic {IDLE, HELD} state_t;

    logic [NUM_BTN-1:0] act, s, req, grant;
    logic [NUM_BTN-1:0] sync_q [NUM_SYNC];
    logic [NUM_BTN-1:0] sync_d [NUM_SYNC];
    state_t             state_q [NUM_BTN];
    state_t             state_d [NUM_BTN];
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] press_q, press_d, release_q, release_d;
    logic               any_press_q, any_press_d, lower, any_held;
`ifdef BTN_REPEAT_EN
    logic [CW-1:0]      hcnt_q [NUM_BTN];
    logic [CW-1:0]      hcnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rep_q, rep_d;
`endif

    always_comb begin
        act       = (BTN_ACTIVE != 0) ? btn_i : ~btn_i;
        sync_d[0] = act;
        for (int i = 1; i < NUM_SYNC; i++) sync_d[i] = sync_q[i-1];
        s = sync_q[NUM_SYNC-1];
    end

    always_comb begin
        any_held = 1'b0;
        for (int n = 0; n < NUM_BTN; n++) any_held = any_held | (state_q[n] == HELD);
        lower = 1'b0;
        for (int n = 0; n < NUM_BTN; n++) begin
            // grant priority runs from channel 0 upward within the same cycle
            req[n]       = (state_q[n] == IDLE) && s[n] && (cnt_q[n] == DB_C);
            grant[n]     = (EXCLUSIVE == 0) || (!any_held && !lower);
            lower        = lower | req[n];
            state_d[n]   = state_q[n];
            cnt_d[n]     = cnt_q[n];
            press_d[n]   = 1'b0;
            release_d[n] = 1'b0;
            if (state_q[n] == IDLE) begin
                if (!s[n]) cnt_d[n] = '0;
                else if (cnt_q[n] != DB_C) cnt_d[n] = cnt_q[n] + 1'b1;
                else if (grant[n]) begin
                    press_d[n] = 1'b1;
                    cnt_d[n]   = '0;
                    state_d[n] = HELD;
                end
            end else begin
                if (s[n]) cnt_d[n] = '0;
                else if (cnt_q[n] != DB_C) cnt_d[n] = cnt_q[n] + 1'b1;
                else begin
                    release_d[n] = 1'b1;
                    cnt_d[n]     = '0;
                    state_d[n]   = IDLE;
                end
            end
`ifdef BTN_REPEAT_EN
            // hold counter only runs while held with s=1, so it never coincides with a release
            hcnt_d[n] = '0;
            rep_d[n]  = 1'b0;
            if (state_q[n] == HELD && s[n]) begin
                hcnt_d[n] = hcnt_q[n] + 1'b1;
                rep_d[n]  = rep_q[n];
                if (hcnt_q[n] == (rep_q[n] ? RP_C : HD_C)) begin
                    press_d[n] = 1'b1;
                    hcnt_d[n]  = '0;
                    rep_d[n]   = 1'b1;
                end
            end
`endif
        end
        any_press_d = |press_d;
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < NUM_SYNC; i++) sync_q[i] <= '0;
            for (int n = 0; n < NUM_BTN; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
`ifdef BTN_REPEAT_EN
                hcnt_q[n]  <= '0;
`endif
            end
`ifdef BTN_REPEAT_EN
            rep_q       <= '0;
`endif
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
`ifdef BTN_REPEAT_EN
            hcnt_q      <= hcnt_d;
            rep_q       <= rep_d;
`endif
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_BTN; n++) level_o[n] = (state_q[n] == HELD);
    end

    assign press_o     = press_q;
    assign release_o   = release_q;
    assign any_press_o = any_press_q;
endmodule

// File: tb/tb_btn_cond_array.sv
// tb_btn_cond_array: scoreboard bench; drivers queue expected strobes, per-DUT monitors pop and compare.
// Three instances: active-high, active-low, exclusive; repeat scenario runs when BTN_REPEAT_EN is defined.
module tb_btn_cond_array;
    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lv;
    } exp_t;

    logic       clk = 1'b0;
    logic       arstn;
    logic [1:0] btn_a, btn_b, btn_c;
    logic [1:0] lv_a, pr_a, rl_a, lv_b, pr_b, rl_b, lv_c, pr_c, rl_c;
    logic       ap_a, ap_b, ap_c;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       q_a[$], q_b[$], q_c[$];
    exp_t       ea, eb, ec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_cond_array #(.NUM_BTN(2), .NUM_SYNC(2), .BTN_ACTIVE(1), .DEBOUNCE(4), .EXCLUSIVE(0),
                     .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) u_a (
        .clk_i(clk), .arstn_i(arstn), .btn_i(btn_a), .level_o(lv_a),
        .press_o(pr_a), .release_o(rl_a), .any_press_o(ap_a));
    btn_cond_array #(.NUM_BTN(2), .NUM_SYNC(2), .BTN_ACTIVE(0), .DEBOUNCE(4), .EXCLUSIVE(0),
                     .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) u_b (
        .clk_i(clk), .arstn_i(arstn), .btn_i(btn_b), .level_o(lv_b),
        .press_o(pr_b), .release_o(rl_b), .any_press_o(ap_b));
    btn_cond_array #(.NUM_BTN(2), .NUM_SYNC(2), .BTN_ACTIVE(1), .DEBOUNCE(4), .EXCLUSIVE(1),
                     .HOLD_CYCLES(20), .REPEAT_CYCLES(8)) u_c (
        .clk_i(clk), .arstn_i(arstn), .btn_i(btn_c), .level_o(lv_c),
        .press_o(pr_c), .release_o(rl_c), .any_press_o(ap_c));

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic spurious(input string nm, input logic [1:0] pr, input logic [1:0] rl);
        total++;
        bad++;
        $display("FAIL %s: unexpected strobe press=%b release=%b expected none (cyc=%0d)", nm, pr, rl, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int c, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lv);
        exp_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.lv  = lv;
        return e;
    endfunction

    always @(negedge clk) if ((pr_a | rl_a) != 2'b00 || ap_a) begin
        if (q_a.size() == 0) spurious("a_spurious", pr_a, rl_a);
        else begin
            ea = q_a.pop_front();
            cmp("a_cycle", cyc, ea.cyc);
            cmp("a_press", pr_a, ea.pr);
            cmp("a_release", rl_a, ea.rl);
            cmp("a_level", lv_a, ea.lv);
            cmp("a_any_press", ap_a, |ea.pr);
        end
    end

    always @(negedge clk) if ((pr_b | rl_b) != 2'b00 || ap_b) begin
        if (q_b.size() == 0) spurious("b_spurious", pr_b, rl_b);
        else begin
            eb = q_b.pop_front();
            cmp("b_cycle", cyc, eb.cyc);
            cmp("b_press", pr_b, eb.pr);
            cmp("b_release", rl_b, eb.rl);
            cmp("b_level", lv_b, eb.lv);
            cmp("b_any_press", ap_b, |eb.pr);
        end
    end

    always @(negedge clk) if ((pr_c | rl_c) != 2'b00 || ap_c) begin
        if (q_c.size() == 0) spurious("c_spurious", pr_c, rl_c);
        else begin
            ec = q_c.pop_front();
            cmp("c_cycle", cyc, ec.cyc);
            cmp("c_press", pr_c, ec.pr);
            cmp("c_release", rl_c, ec.rl);
            cmp("c_level", lv_c, ec.lv);
            cmp("c_any_press", ap_c, |ec.pr);
        end
    end

    initial begin
        arstn = 1'b0;
        btn_a = 2'b11;
        btn_b = 2'b11;
        btn_c = 2'b00;
        tick(3);
        cmp("rst_level", lv_a, 2'b00);
        cmp("rst_press", pr_a, 2'b00);
        cmp("rst_release", rl_a, 2'b00);
        cmp("rst_any_press", ap_a, 1'b0);
        cmp("rst_level_b", lv_b, 2'b00);
        cmp("rst_level_c", lv_c, 2'b00);
        // both channels held through reset release
        arstn = 1'b1;
        q_a.push_back(mk(cyc + 7, 2'b11, 2'b00, 2'b11));
        tick(10);
        btn_a = 2'b00;
        q_a.push_back(mk(cyc + 7, 2'b00, 2'b11, 2'b00));
        tick(12);
        // 4-sample glitch must be rejected
        btn_a = 2'b01;
        tick(4);
        btn_a = 2'b00;
        tick(10);
        cmp("glitch_level", lv_a, 2'b00);
        // 5-sample pulse is accepted, release follows the falling edge
        btn_a = 2'b01;
        q_a.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b01));
        tick(5);
        btn_a = 2'b00;
        q_a.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
        tick(12);
        // active-low instance
        btn_b = 2'b01;
        q_b.push_back(mk(cyc + 7, 2'b10, 2'b00, 2'b10));
        tick(10);
        cmp("actlow_level", lv_b, 2'b10);
        btn_b = 2'b11;
        q_b.push_back(mk(cyc + 7, 2'b00, 2'b10, 2'b00));
        tick(12);
        // exclusive instance: ch1 waits until ch0 is back in IDLE
        btn_c = 2'b11;
        q_c.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b01));
        tick(10);
        btn_c = 2'b10;
        q_c.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
        q_c.push_back(mk(cyc + 8, 2'b10, 2'b00, 2'b10));
        tick(12);
        btn_c = 2'b00;
        q_c.push_back(mk(cyc + 7, 2'b00, 2'b10, 2'b00));
        tick(12);
        // reset while held: no release strobe, fresh press afterwards
        btn_a = 2'b01;
        q_a.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b01));
        tick(10);
        cmp("hold_level", lv_a, 2'b01);
        arstn = 1'b0;
        tick(1);
        cmp("midrst_level", lv_a, 2'b00);
        cmp("midrst_release", rl_a, 2'b00);
        arstn = 1'b1;
        q_a.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b01));
        tick(10);
        btn_a = 2'b00;
        q_a.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
        tick(12);
`ifdef BTN_REPEAT_EN
        btn_a = 2'b01;
        q_a.push_back(mk(cyc + 7, 2'b01, 2'b00, 2'b01));
        for (int k = 0; k < 5; k++) q_a.push_back(mk(cyc + 27 + 8 * k, 2'b01, 2'b00, 2'b01));
        tick(60);
        btn_a = 2'b00;
        q_a.push_back(mk(cyc + 7, 2'b00, 2'b01, 2'b00));
        tick(12);
`endif
        tick(20);
        cmp("a_missing", q_a.size(), 0);
        cmp("b_missing", q_b.size(), 0);
        cmp("c_missing", q_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_cond_array.md
Name: btn_cond_array

Overview:
- Parametrised, multi-channel successor to the single-state up/down button front end used ahead of the freq_gen tick controller.
- Conditions NUM_BTN raw push-buttons. Per channel: polarity normalisation, NUM_SYNC-stage synchroniser, independent press/release debounce FSM, and single-cycle press/release strobes.
- Optional long-press auto-repeat.
- Strobes feed freq_up_i/freq_dwn_i-style step inputs and any other event consumer in the FPGA top.

Parameters:
- NUM_BTN, 2, number of button channels (>=1).
- NUM_SYNC, 2, synchroniser depth per channel (>=1).
- BTN_ACTIVE, 1, 1 = buttons active-high, 0 = active-low (applies to all channels).
- DEBOUNCE, 100000, stable cycles required beyond the first sample (>=1).
- EXCLUSIVE, 0, 1 = at most one channel may be in HELD at a time. Lowest index wins a same-cycle contest.
- HOLD_CYCLES, 50000000, long-press delay before the first repeat (used only with BTN_REPEAT_EN).
- REPEAT_CYCLES, 10000000, period between repeat strobes (used only with BTN_REPEAT_EN).

Ports:
- clk_i  in  1  system clock.
- arstn_i  in  1  reset. Synchronous, active-low. Sampled only on rising clk_i.
- btn_i  in  NUM_BTN  raw button inputs, asynchronous.
- level_o  out  NUM_BTN  debounced state, 1 = channel in HELD.
- press_o  out  NUM_BTN  one-cycle strobe on debounced press; also carries repeat strobes.
- release_o  out  NUM_BTN  one-cycle strobe on debounced release.
- any_press_o  out  1  OR of press_o.

Behaviour:
- Reset: while arstn_i=0 at a clk_i edge, the following are cleared to 0 and every FSM goes to IDLE:
  - synchronisers
  - counters
  - level_o, press_o, release_o, any_press_o
- Reset mid-debounce or mid-hold discards progress. No strobe is emitted by reset.
- Normalisation: act[n] = BTN_ACTIVE ? btn_i[n] : ~btn_i[n]. It feeds sync stage 0. s[n] is the last sync stage.
- Counter width: $clog2(max(DEBOUNCE, HOLD_CYCLES, REPEAT_CYCLES)+1) per channel, one debounce/hold counter per channel. Counters never wrap; every terminal compare resets the counter.
- FSM per channel, states IDLE and HELD:
  - IDLE:
    - s=0: cnt<=0.
    - s=1 and cnt<DEBOUNCE: cnt++.
    - s=1 and cnt==DEBOUNCE and grant: press_o<=1, level_o<=1, cnt<=0, go HELD.
    - s=1 and cnt==DEBOUNCE with grant denied (EXCLUSIVE): hold cnt at DEBOUNCE and stay IDLE; press is taken when grant frees.
  - HELD:
    - s=0 and cnt<DEBOUNCE: cnt++.
    - s=0 and cnt==DEBOUNCE: release_o<=1, level_o<=0, cnt<=0, go IDLE.
    - s=1: release count cleared.
- Latency:
  - Input stable from edge k: press_o is high during the cycle after edge k+NUM_SYNC+DEBOUNCE.
  - Release uses the same latency.
  - A glitch shorter than DEBOUNCE+1 synchronised samples yields no strobe.
- Strobes are registered, exactly one cycle wide, and cleared the following cycle.
- Grant:
  - EXCLUSIVE=0: always granted.
  - EXCLUSIVE=1: granted only if no channel is in HELD and no lower-index channel is requesting press that cycle.
- Simultaneous presses with EXCLUSIVE=0 strobe in the same cycle. any_press_o is the registered OR, aligned with press_o.

Optional Feature:
- Macro BTN_REPEAT_EN.
- Defined: each channel has a separate hold counter (same width) that is active only in HELD with s=1.
  - After HOLD_CYCLES cycles in HELD: a press_o strobe is emitted.
  - Then one strobe every REPEAT_CYCLES until the channel leaves HELD or s drops.
  - s dropping clears the hold counter. If s returns before release completes, the full HOLD_CYCLES applies again.
  - A repeat strobe and a release strobe are never emitted in the same cycle; release wins.
- Undefined: no hold counters are synthesised, HOLD_CYCLES/REPEAT_CYCLES are ignored, and exactly one press_o strobe is emitted per debounced press.

Test Plan:
1. Reset: NUM_BTN=2, DEBOUNCE=4, NUM_SYNC=2, BTN_ACTIVE=1. Hold arstn_i=0 for 3 cycles with btn_i=2'b11 -> all outputs 0. Release reset with btn_i held -> press_o=2'b11 and any_press_o=1 appear 7 cycles later.
2. Glitch reject: btn_i[0] high for 4 cycles, then low -> no press_o/release_o strobe, level_o stays 0. Next, high for 5 cycles -> one press_o[0] strobe. Drop it -> release_o[0] 7 cycles after the falling edge.
3. Active-low: BTN_ACTIVE=0, btn_i idles at 2'b11. Drive btn_i[1]=0 for 10 cycles -> press_o=2'b10 once, level_o[1]=1.
4. Exclusive: EXCLUSIVE=1, both buttons asserted on the same cycle -> only press_o[0]. Release ch0 -> release_o[0], then press_o[1] one cycle after ch0 reaches IDLE.
5. Repeat: BTN_REPEAT_EN, HOLD_CYCLES=20, REPEAT_CYCLES=8, ch0 held for 60 cycles.
   - Presses at t, t+20, t+28, t+36, t+44, t+52 (t = first press cycle).
   - Then release_o[0] after the debounce.
6. Reset mid-hold: assert arstn_i=0 while level_o[0]=1 -> level_o=0 next cycle with no release_o strobe. Keep button held after reset -> fresh press after 7 cycles.
